// File: rtl/rr_arbiter8_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
package arb_pkg;

  localparam int ARB_N            = 8;
  localparam int ARB_IDW          = 3;
  localparam int ARB_MAX_HOLD_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // One-hot decode of a requester index.
  function automatic logic [ARB_N-1:0] id2onehot(input logic [ARB_IDW-1:0] id);
    logic [ARB_N-1:0] v;
    v = 8'h01 << id;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Requester/grant bundle between the requester ports and the arbiter.
interface rr_arbiter8_if;
  import arb_pkg::*;

  logic [ARB_N-1:0]   req;
  logic [ARB_N-1:0]   gnt;
  logic [ARB_IDW-1:0] gnt_id;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/rr_arbiter8_chk.sv
// Structural invariants of the arbiter outputs, bound to the grant signals.
module rr_arbiter8_chk
  import arb_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  input logic [ARB_N-1:0]   gnt,
  input logic [ARB_IDW-1:0] gnt_id,
  input logic               gnt_valid,
  input logic               timeout
);

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));

  a_valid_matches: assert property (@(posedge clk) disable iff (!rst_n)
    gnt_valid == (|gnt));

  a_id_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    gnt_valid |-> (gnt == id2onehot(gnt_id)));

  a_idle_id_zero: assert property (@(posedge clk) disable iff (!rst_n)
    !gnt_valid |-> (gnt_id == 3'd0));

  a_timeout_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    timeout |=> !timeout);

endmodule

// File: rtl/rr_arbiter8_pick.sv
// Combinational rotating-priority picker: lowest masked request at or above ptr, wrapping.
module rr_pick
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]   req,
  input  logic [ARB_N-1:0]   mask,
  input  logic [ARB_IDW-1:0] ptr,
  output logic               any,
  output logic [ARB_IDW-1:0] idx,
  output logic [ARB_N-1:0]   onehot
);

  logic [ARB_N-1:0]   masked_s;
  logic [ARB_N-1:0]   rot_s;
  logic [ARB_IDW-1:0] enc_s;
  logic               found_s;

  assign masked_s = req & ~mask;

  // Rotate so that bit ptr lands at position 0.
  always_comb begin
    rot_s = 8'h00;
    for (int i = 0; i < ARB_N; i++) begin
      logic [ARB_IDW-1:0] src;
      src      = ptr + ARB_IDW'(i);
      rot_s[i] = masked_s[src];
    end
  end

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    enc_s   = 3'd0;
    found_s = 1'b0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        enc_s   = ARB_IDW'(i);
        found_s = 1'b1;
      end else begin
        enc_s   = enc_s;
        found_s = found_s;
      end
    end
  end

  assign any    = found_s;
  assign idx    = enc_s + ptr;
  assign onehot = found_s ? id2onehot(idx) : 8'h00;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with hold-until-release grants.
// Optional grant watchdog compiled in with RR_ARB_TIMEOUT_EN.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input logic          clk,
  input logic          rst_n,
  rr_arbiter8_if.slave bus
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD out of range 2..255");
  end

  arb_state_e         state_r, state_nxt_s;
  logic [ARB_IDW-1:0] ptr_r, ptr_nxt_s;
  logic [ARB_N-1:0]   gnt_r, gnt_nxt_s;
  logic [ARB_IDW-1:0] gnt_id_r, gnt_id_nxt_s;
  logic               gnt_valid_r, gnt_valid_nxt_s;

  logic               owner_req_s;
  logic               release_s;
  logic               revoke_s;
  logic [ARB_IDW-1:0] pick_ptr_s;
  logic [ARB_N-1:0]   pick_mask_s;
  logic               pick_any_s;
  logic [ARB_IDW-1:0] pick_idx_s;
  logic [ARB_N-1:0]   pick_onehot_s;

  assign owner_req_s = bus.req[gnt_id_r];
  assign release_s   = (state_r == ST_GRANT) && !owner_req_s;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_r;
  logic       timeout_r;
  logic       new_grant_s;

  assign revoke_s    = (state_r == ST_GRANT) && owner_req_s && (hold_cnt_r == HOLD_LAST);
  assign new_grant_s = ((state_r == ST_IDLE) || release_s || revoke_s) && pick_any_s;

  // Hold counter restarts on each new owner and counts every cycle the owner keeps the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_r <= 8'd0;
      timeout_r  <= 1'b0;
    end else begin
      timeout_r <= revoke_s;
      if (new_grant_s) begin
        hold_cnt_r <= 8'd0;
      end else if (state_nxt_s == ST_GRANT) begin
        hold_cnt_r <= hold_cnt_r + 8'd1;
      end else begin
        hold_cnt_r <= 8'd0;
      end
    end
  end

  assign bus.timeout = timeout_r;
`else
  assign revoke_s    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // On a hand-off the pointer moves past the departing owner before the re-pick.
  assign pick_ptr_s  = (release_s || revoke_s) ? (gnt_id_r + 3'd1) : ptr_r;
  assign pick_mask_s = revoke_s ? id2onehot(gnt_id_r) : 8'h00;

  rr_pick u_pick (
    .req    (bus.req),
    .mask   (pick_mask_s),
    .ptr    (pick_ptr_s),
    .any    (pick_any_s),
    .idx    (pick_idx_s),
    .onehot (pick_onehot_s)
  );

  // Next-state and next-output decision.
  always_comb begin
    state_nxt_s     = state_r;
    ptr_nxt_s       = ptr_r;
    gnt_nxt_s       = gnt_r;
    gnt_id_nxt_s    = gnt_id_r;
    gnt_valid_nxt_s = gnt_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_nxt_s     = ST_GRANT;
          gnt_nxt_s       = pick_onehot_s;
          gnt_id_nxt_s    = pick_idx_s;
          gnt_valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s     = ST_IDLE;
          gnt_nxt_s       = 8'h00;
          gnt_id_nxt_s    = 3'd0;
          gnt_valid_nxt_s = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_s || revoke_s) begin
          ptr_nxt_s = pick_ptr_s;
          if (pick_any_s) begin
            state_nxt_s     = ST_GRANT;
            gnt_nxt_s       = pick_onehot_s;
            gnt_id_nxt_s    = pick_idx_s;
            gnt_valid_nxt_s = 1'b1;
          end else begin
            state_nxt_s     = ST_IDLE;
            gnt_nxt_s       = 8'h00;
            gnt_id_nxt_s    = 3'd0;
            gnt_valid_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s     = ST_GRANT;
          gnt_nxt_s       = gnt_r;
          gnt_id_nxt_s    = gnt_id_r;
          gnt_valid_nxt_s = gnt_valid_r;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        ptr_nxt_s       = 3'd0;
        gnt_nxt_s       = 8'h00;
        gnt_id_nxt_s    = 3'd0;
        gnt_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= 3'd0;
      gnt_r       <= 8'h00;
      gnt_id_r    <= 3'd0;
      gnt_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      gnt_r       <= gnt_nxt_s;
      gnt_id_r    <= gnt_id_nxt_s;
      gnt_valid_r <= gnt_valid_nxt_s;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_id    = gnt_id_r;
  assign bus.gnt_valid = gnt_valid_r;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed, table-driven bench for rr_arbiter8.
module tb_rr_arbiter8;
  import arb_pkg::*;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[20];

  always #5 clk = ~clk;

  rr_arbiter8_if bus_if ();

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  rr_arbiter8_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .gnt       (bus_if.gnt),
    .gnt_id    (bus_if.gnt_id),
    .gnt_valid (bus_if.gnt_valid),
    .timeout   (bus_if.timeout)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] g, input logic [2:0] id,
                           input logic v, input logic to);
    check({name, ".gnt"}, bus_if.gnt, g);
    check({name, ".gnt_id"}, {5'd0, bus_if.gnt_id}, {5'd0, id});
    check({name, ".gnt_valid"}, {7'd0, bus_if.gnt_valid}, {7'd0, v});
    check({name, ".timeout"}, {7'd0, bus_if.timeout}, {7'd0, to});
  endtask

  task automatic step(input logic [7:0] r);
    @(negedge clk);
    bus_if.req = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rotation: all request, each owner drops its own request for one cycle
    vecs[0]  = '{8'hFE, 8'h02, 3'd1, 1'b1};
    vecs[1]  = '{8'hFD, 8'h04, 3'd2, 1'b1};
    vecs[2]  = '{8'hFB, 8'h08, 3'd3, 1'b1};
    vecs[3]  = '{8'hF7, 8'h10, 3'd4, 1'b1};
    vecs[4]  = '{8'hEF, 8'h20, 3'd5, 1'b1};
    vecs[5]  = '{8'hDF, 8'h40, 3'd6, 1'b1};
    vecs[6]  = '{8'hBF, 8'h80, 3'd7, 1'b1};
    vecs[7]  = '{8'h7F, 8'h01, 3'd0, 1'b1};
    vecs[8]  = '{8'hFF, 8'h01, 3'd0, 1'b1};
    // wrap: owner 6 releases with only 0 and 1 pending
    vecs[9]  = '{8'h40, 8'h40, 3'd6, 1'b1};
    vecs[10] = '{8'h03, 8'h01, 3'd0, 1'b1};
    vecs[11] = '{8'h02, 8'h02, 3'd1, 1'b1};
    vecs[12] = '{8'h00, 8'h00, 3'd0, 1'b0};
    // idle pick from ptr=2, then simultaneous release of 3 and request of 5
    vecs[13] = '{8'h08, 8'h08, 3'd3, 1'b1};
    vecs[14] = '{8'h20, 8'h20, 3'd5, 1'b1};
    vecs[15] = '{8'hFF, 8'h20, 3'd5, 1'b1};
    vecs[16] = '{8'hDF, 8'h40, 3'd6, 1'b1};
    vecs[17] = '{8'h00, 8'h00, 3'd0, 1'b0};
    vecs[18] = '{8'h03, 8'h01, 3'd0, 1'b1};
    vecs[19] = '{8'h00, 8'h00, 3'd0, 1'b0};

    bus_if.req = 8'hFF;
    rst_n      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("reset[%0d]", i), 8'h00, 3'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("first_pick", 8'h01, 3'd0, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].req);
      check_out($sformatf("vec[%0d]", i), vecs[i].gnt, vecs[i].id, vecs[i].valid, 1'b0);
    end

    // asynchronous reset while requester 4 owns the resource
    step(8'h10);
    check_out("pre_async", 8'h10, 3'd4, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    bus_if.req = 8'hFF;
    rst_n      = 1'b1;
    @(posedge clk);
    #1;
    check_out("post_async", 8'h01, 3'd0, 1'b1, 1'b0);

    // watchdog: 2 holds while 4 waits (ptr=1 after owner 0 leaves)
    step(8'h00);
    check_out("to_idle", 8'h00, 3'd0, 1'b0, 1'b0);
    step(8'h14);
    check_out("hold[0]", 8'h04, 3'd2, 1'b1, 1'b0);
`ifdef RR_ARB_TIMEOUT_EN
    for (int i = 1; i < 4; i++) begin
      step(8'h14);
      check_out($sformatf("hold[%0d]", i), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    step(8'h14);
    check_out("revoke", 8'h10, 3'd4, 1'b1, 1'b1);
    step(8'h14);
    check_out("after_revoke", 8'h10, 3'd4, 1'b1, 1'b0);
`else
    for (int i = 1; i < 12; i++) begin
      step(8'h14);
      check_out($sformatf("hold[%0d]", i), 8'h04, 3'd2, 1'b1, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one downstream resource among eight requesters. Each cycle without an owner, it picks a winner with rotating priority and holds the grant until the owner drops its request. The rotation pointer advances past each owner, so no requester starves. It sits between the requester ports and the shared datapath and drives that datapath's select and enable.

## Interface
- N, 8: number of requesters; fixed at 8 in this revision. ID width is 3.
- MAX_HOLD, 16: maximum grant length in cycles. Used only when the timeout feature is compiled in. Legal range 2..255.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  N  request per requester; held high for as long as the requester wants or owns the resource
- gnt  output  N  one-hot grant, registered
- gnt_id  output  3  binary index of the current owner; valid only when gnt_valid=1
- gnt_valid  output  1  high while any grant is active; equals |gnt
- timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog; tied 0 when the feature is compiled out

## Operation
- States: IDLE (no owner) and GRANT (owner = gnt_id).
- Rotating pick:
  - Candidate set is req, with masking where stated below.
  - Winner is the first set bit found by scanning upward from ptr, wrapping 7→0.
  - ptr is 3 bits, wraps naturally, and resets to 0.
- IDLE:
  - If any req is set, load gnt, gnt_id and gnt_valid with the winner and go to GRANT.
  - Otherwise stay in IDLE with all outputs 0.
- GRANT, req[gnt_id]=1: hold all outputs. Requests from other requesters are ignored.
- GRANT, req[gnt_id]=0 (release):
  - ptr ← gnt_id+1.
  - Pick again from req using the new ptr, in the same edge.
  - If there is a winner, grant it directly with no idle bubble and stay in GRANT.
  - If there is none, clear outputs and go to IDLE.
- If a new request and the owner's release arrive in the same cycle, the new request takes part in the same-edge re-pick.
- Invariant: gnt is always one-hot or zero, and gnt_id is consistent with gnt.
- Reset mid-grant: all outputs drop asynchronously, ptr=0, state=IDLE. The first pick after reset scans from index 0.

## Timing
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, timeout=0, ptr=0, hold counter=0, state IDLE.
- Grant latency: 1 cycle. req sampled at edge k gives gnt visible after edge k.
- Release latency: 1 cycle. req[owner] low at edge k drops the owner's gnt after edge k. The next owner's gnt rises on that same edge.
- The arbiter never asserts a grant to a requester whose req was low at the deciding edge.
- All outputs come from flops; there is no combinational path from req to gnt.

## Configuration
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 and req[owner] is still 1, the grant is revoked on the next edge.
  - On revoke: timeout pulses for 1 cycle and ptr ← owner+1.
  - The re-pick in that edge masks the revoked owner. The next owner is granted on the same edge, or the arbiter goes to IDLE if nobody else requests.
  - The revoked requester may win again in later picks if it keeps req high.
- Not defined: no counter, timeout is tied 0, and grants are held indefinitely.

## Structure
- Package arb_pkg holds:
  - state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1
  - ARB_N=8 and ARB_IDW=3
  - the default MAX_HOLD constant
- Sub-module rr_pick is purely combinational:
  - Inputs: req[7:0], mask[7:0], ptr[2:0].
  - Outputs: any, idx[2:0], onehot[7:0].
  - It rotates the masked request vector by ptr, priority-encodes the lowest set bit, and rotates the index back.
- rr_arbiter8 holds the state, ptr, output registers and the optional hold counter.

## Test plan
- Reset check: hold rst_n=0 with req=8'hFF, then release → gnt stays 0 during reset; one edge after release gnt=8'h01, gnt_id=0.
- Round-robin rotation: req=8'hFF held, each owner drops its own req for one cycle → grants go 0,1,2,…,7,0 in order with no idle cycle between owners.
- Wrap: owner 6 releases while req=8'b0000_0011 → ptr=7, next grant is gnt_id=0 (not 1); then 0 releases → gnt_id=1.
- Simultaneous release and new request: owner 3 drops req in the same cycle req[5] rises, nothing else pending → gnt=8'h20 on that edge.
- Asynchronous reset mid-grant: assert rst_n low between edges while gnt=8'h10 → gnt, gnt_valid and gnt_id go to 0 immediately; after release the pick starts from index 0.
- Timeout (RR_ARB_TIMEOUT_EN, MAX_HOLD=4): requester 2 holds req, requester 4 also requests → gnt_id=2 for exactly 4 cycles, then timeout pulses for 1 cycle and gnt_id=4 on the same edge. Without the macro, gnt_id stays 2 indefinitely.
